// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: frame-tick paced stepping of the head
// square with wrap-around, direction buffering with reverse rejection,
// and an IDLE -> PLAY -> OVER game flow with a timed game-over hold.
module snake_move_ctrl #(
   parameter int HRES        = 256,
   parameter int VRES        = 240,
   parameter int SNAKE_SIZE  = 8,
   parameter int SNAKE_SPEED = 1,
   parameter int STEP_DIV    = 4,
   parameter int OVER_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       vsync,
   input  logic       start,
   input  logic [3:0] switches_p1,
   input  logic       collide,
   output logic [8:0] snake_x,
   output logic [8:0] snake_y,
   output logic [1:0] snake_d,
   output logic [1:0] state,
   output logic       move_stb
);

   localparam logic [8:0] X_MAX     = 9'(HRES - SNAKE_SIZE);
   localparam logic [8:0] Y_MAX     = 9'(VRES - SNAKE_SIZE);
   localparam logic [8:0] X_CTR     = 9'((HRES - SNAKE_SIZE) / 2);
   localparam logic [8:0] Y_CTR     = 9'((VRES - SNAKE_SIZE) / 2);
   localparam logic [8:0] SPEED     = 9'(SNAKE_SPEED);
   localparam logic [7:0] STEP_LAST = 8'(STEP_DIV - 1);
   localparam logic [7:0] OVER_LOAD = 8'(OVER_FRAMES);

   localparam logic [1:0] DIR_L = 2'd0;
   localparam logic [1:0] DIR_R = 2'd1;
   localparam logic [1:0] DIR_U = 2'd2;
   localparam logic [1:0] DIR_D = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2,
      S_BAD  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [8:0] x_q, x_d;
   logic [8:0] y_q, y_d;
   logic [1:0] dir_q, dir_d;
   logic [1:0] pend_q, pend_d;
   logic [7:0] cnt_q, cnt_d;
   logic       vsync_q;
   logic       armed_q, armed_d;
   logic       move_stb_q, move_stb_d;

   logic       frame_tick;
   logic       sw_valid;
   logic [1:0] sw_dir;
   logic [8:0] step_x, step_y;
   logic       do_move;
   logic       go_idle;
   logic [1:0] ref_dir;

   // armed_q blocks a tick until vsync has been seen low after reset, so a
   // vsync already high at reset release cannot fake a rising edge.
   assign frame_tick = vsync & ~vsync_q & armed_q;

   // Direction buttons, priority left > right > up > down.
   always_comb begin
      sw_valid = 1'b1;
      sw_dir   = DIR_L;
      if (switches_p1[0])      sw_dir = DIR_L;
      else if (switches_p1[1]) sw_dir = DIR_R;
      else if (switches_p1[2]) sw_dir = DIR_U;
      else if (switches_p1[3]) sw_dir = DIR_D;
      else                     sw_valid = 1'b0;
   end

   // Candidate next position one step along the pending direction, wrapped.
   always_comb begin
      step_x = x_q;
      step_y = y_q;
      case (pend_q)
         DIR_L: step_x = (x_q < SPEED) ? X_MAX : x_q - SPEED;
         DIR_R: step_x = (({1'b0, x_q} + {1'b0, SPEED}) > {1'b0, X_MAX}) ? 9'd0 : x_q + SPEED;
         DIR_U: step_y = (y_q < SPEED) ? Y_MAX : y_q - SPEED;
         default: step_y = (({1'b0, y_q} + {1'b0, SPEED}) > {1'b0, Y_MAX}) ? 9'd0 : y_q + SPEED;
      endcase
   end

   // Next-state, counter, position and direction logic.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_d      = dir_q;
      pend_d     = pend_q;
      cnt_d      = cnt_q;
      move_stb_d = 1'b0;
      armed_d    = armed_q | ~vsync;
      go_idle    = 1'b0;
      do_move    = 1'b0;
      ref_dir    = dir_q;

      case (state_q)
         S_IDLE: begin
            go_idle = 1'b1;
            if (start) state_d = S_PLAY;
         end
         S_PLAY: begin
            do_move = frame_tick && !collide && (cnt_q >= STEP_LAST);
            // In a move cycle the direction about to be applied is pend_q,
            // so reverse rejection must be judged against it.
            ref_dir = do_move ? pend_q : dir_q;
            if (sw_valid && (sw_dir != (ref_dir ^ 2'd1))) pend_d = sw_dir;
            if (collide) begin
               state_d = S_OVER;
               cnt_d   = OVER_LOAD;
            end else if (frame_tick) begin
               if (do_move) begin
                  cnt_d      = 8'd0;
                  x_d        = step_x;
                  y_d        = step_y;
                  dir_d      = pend_q;
                  move_stb_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_OVER: begin
            if (frame_tick) begin
               if (cnt_q <= 8'd1) begin
                  state_d = S_IDLE;
                  go_idle = 1'b1;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            go_idle = 1'b1;
         end
      endcase

      // Entering or sitting in IDLE recentres the head.
      if (go_idle) begin
         x_d    = X_CTR;
         y_d    = Y_CTR;
         dir_d  = DIR_R;
         pend_d = DIR_R;
         cnt_d  = 8'd0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         x_q        <= X_CTR;
         y_q        <= Y_CTR;
         dir_q      <= DIR_R;
         pend_q     <= DIR_R;
         cnt_q      <= 8'd0;
         vsync_q    <= 1'b0;
         armed_q    <= 1'b0;
         move_stb_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         vsync_q    <= vsync;
         armed_q    <= armed_d;
         move_stb_q <= move_stb_d;
      end
   end

   assign snake_x  = x_q;
   assign snake_y  = y_q;
   assign snake_d  = dir_q;
   assign state    = state_q;
   assign move_stb = move_stb_q;

endmodule

// File: doc/snake_move_ctrl.md
SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

Interface
REQ-001 Parameter HRES, default 256, visible width in pixels.
REQ-002 Parameter VRES, default 240, visible height in pixels.
REQ-003 Parameter SNAKE_SIZE, default 8, head square edge in pixels.
REQ-004 Parameter SNAKE_SPEED, default 1, pixels per move.
REQ-005 Parameter STEP_DIV, default 4, frame ticks per move, range 1..15.
REQ-006 Parameter OVER_FRAMES, default 60, frame ticks spent in OVER, range 1..255.
REQ-007 Port clk, input, 1, system clock; the block has one clock and reset is asynchronous and active-low.
REQ-008 Port reset_n, input, 1, asynchronous active-low reset.
REQ-009 Port vsync, input, 1, frame sync level from the sync generator, synchronous to clk.
REQ-010 Port start, input, 1, player start button, level.
REQ-011 Port switches_p1, input, 4, direction buttons: [0] left, [1] right, [2] up, [3] down.
REQ-012 Port collide, input, 1, collision flag from the collision detector, level.
REQ-013 Port snake_x, output, 9, head left edge in pixels.
REQ-014 Port snake_y, output, 9, head top edge in pixels.
REQ-015 Port snake_d, output, 2, applied direction: 0 left, 1 right, 2 up, 3 down.
REQ-016 Port state, output, 2, 0 IDLE, 1 PLAY, 2 OVER.
REQ-017 Port move_stb, output, 1, one-cycle pulse in the cycle after a position update.

Function
REQ-018 Frame tick SHALL be vsync high AND registered vsync (previous cycle) low; exactly one tick per vsync rising edge.
REQ-019 IDLE: snake_x=(HRES-SNAKE_SIZE)/2, snake_y=(VRES-SNAKE_SIZE)/2, snake_d=1, pending dir=1, frame counter=0; start high -> PLAY next cycle.
REQ-020 PLAY: every cycle, the pending direction SHALL load from switches_p1 with priority left>right>up>down; with no switch pressed it holds.
REQ-021 Pending direction equal to the reverse of snake_d (0<->1, 2<->3) SHALL be rejected; pending keeps its previous value.
REQ-022 PLAY: each frame tick increments the frame counter; at STEP_DIV-1 the counter clears and a move occurs in the same cycle.
REQ-023 Move: snake_d<=pending; position steps by SNAKE_SPEED in the pending direction; move_stb=1 on the following cycle only.
REQ-024 Wrap: left at x==0 -> x=HRES-SNAKE_SIZE; right at x==HRES-SNAKE_SIZE -> 0; up at y==0 -> VRES-SNAKE_SIZE; down at y==VRES-SNAKE_SIZE -> 0.
REQ-025 PLAY: collide high -> OVER next cycle; a move coincident with collide SHALL be suppressed (collide wins).
REQ-026 OVER: position and snake_d frozen; frame counter reused as an 8-bit countdown loaded with OVER_FRAMES on entry, decremented per tick; at 0 -> IDLE.
REQ-027 start and switches_p1 SHALL be ignored in OVER; collide SHALL be ignored in IDLE and OVER.
REQ-028 Unused state encoding 3 SHALL return to IDLE next cycle.
REQ-029 All arithmetic is 9-bit unsigned; no intermediate value outside 0..HRES-1 or 0..VRES-1 may reach the outputs.

Reset
REQ-030 reset_n low SHALL immediately force state=IDLE, snake_x=124, snake_y=116 (defaults), snake_d=1, move_stb=0, counters=0, vsync register=0.
REQ-031 Reset asserted mid-move or in OVER SHALL abort the operation with no residual move_stb after release.
REQ-032 After reset_n rises, a vsync already high SHALL produce no tick until it goes low and rises again.

Verification
REQ-033 Reset, start=1 one cycle, 4 ticks, no switches -> PLAY, x 124->125 on 4th tick, one move_stb, y=116.
REQ-034 PLAY, d=1, switches_p1=4'b0001 (left) -> pending rejected; after next move d=1, x incremented.
REQ-035 x=0, switch left pressed while d=2, STEP_DIV ticks -> d=0, x=248.
REQ-036 collide=1 in the same cycle as the move tick -> state=2, x/y unchanged, no move_stb.
REQ-037 OVER, 60 ticks with start held and switches toggling -> state=0 after 60th tick, position recentred to 124/116.
REQ-038 reset_n pulsed low during OVER countdown -> IDLE at once, outputs at reset values, no move_stb.
